// File: rtl/race_pkg.sv
// race_pkg: shared encodings for the race controller slice.
//   race_state_e : FSM state encoding, also driven out on the state port
//   WIN_*        : winner codes
//   TIME_MAX     : race_time saturation value (whole seconds)
//   NUM_CARS     : number of cars tracked
package race_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COUNTDOWN = 2'd1,
    ST_RACING    = 2'd2,
    ST_FINISHED  = 2'd3
  } race_state_e;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;
  localparam logic [1:0] WIN_DRAW = 2'd3;

  localparam logic [9:0] TIME_MAX = 10'd999;

  localparam int NUM_CARS = 2;

endpackage

// File: rtl/lap_check.sv
// lap_check: per-car lap qualification.
//   pclk, rst          : clock, async active-high reset
//   lap_finished       : level, car is inside the finish zone
//   checkpoints_passed : car has passed every checkpoint this lap
//   lap_valid          : combinational; entry into the finish zone with all
//                        checkpoints passed, sampled in the entry cycle only
module lap_check (
  input  logic pclk,
  input  logic rst,
  input  logic lap_finished,
  input  logic checkpoints_passed,
  output logic lap_valid
);

  logic lap_prev;

  // Tracked in every state so a zone entry that began before RACING
  // cannot be seen as a fresh edge later.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) lap_prev <= 1'b0;
    else     lap_prev <= lap_finished;
  end

  assign lap_valid = lap_finished && !lap_prev && checkpoints_passed;

endmodule

// File: rtl/sec_tick.sv
// sec_tick: one-second prescaler.
//   pclk, rst : clock, async active-high reset
//   en        : count while high; counter is held at 0 while low
//   clr       : synchronous clear, wins over en
//   tick      : one-cycle pulse in the cycle the count sits at CLK_HZ-1
module sec_tick #(
  parameter int CLK_HZ = 65_000_000
) (
  input  logic pclk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt;

  assign tick = en && !clr && (cnt == LAST);

  always_ff @(posedge pclk or posedge rst) begin
    if (rst)                          cnt <= '0;
    else if (clr || !en || cnt == LAST) cnt <= '0;
    else                              cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/race_controller.sv
// race_controller: two-player race sequencer.
//   pclk, rst                : pixel clock, async active-high reset
//   start, abort             : race control levels (abort has priority)
//   lap_finished_pN          : car N inside the finish zone
//   checkpoints_passed_pN    : car N passed all checkpoints this lap
//   state                    : 0 idle, 1 countdown, 2 racing, 3 finished
//   countdown                : seconds left in countdown, else 0
//   race_active              : high only while racing (gates car motion)
//   ckpt_clear               : one-cycle clear to the checkpoint trackers
//   laps_pN                  : valid laps completed by car N
//   race_time                : whole seconds raced, saturating at 999
//   winner                   : 0 none, 1 car 1, 2 car 2, 3 draw
// All outputs are registered.
module race_controller
  import race_pkg::*;
#(
  parameter int LAPS        = 3,
  parameter int CLK_HZ      = 65_000_000,
  parameter int COUNTDOWN_S = 3
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       lap_finished_p1,
  input  logic       checkpoints_passed_p1,
  input  logic       lap_finished_p2,
  input  logic       checkpoints_passed_p2,
  output logic [1:0] state,
  output logic [1:0] countdown,
  output logic       race_active,
  output logic       ckpt_clear,
  output logic [3:0] laps_p1,
  output logic [3:0] laps_p2,
  output logic [9:0] race_time,
  output logic [1:0] winner
);

  localparam logic [3:0] LAPS_W = 4'(LAPS);
  localparam logic [1:0] CD_W   = 2'(COUNTDOWN_S);

  race_state_e                       state_q, state_n;
  logic [1:0]                        cd_n;
  logic                              act_n, clr_n;
  logic [NUM_CARS-1:0][3:0]          laps_q, laps_n;
  logic [9:0]                        time_n;
  logic [1:0]                        win_n;
  logic [NUM_CARS-1:0]               lap_fin, lap_ckpt, lap_valid, done;
  logic                              tick, go;

  assign lap_fin  = {lap_finished_p2, lap_finished_p1};
  assign lap_ckpt = {checkpoints_passed_p2, checkpoints_passed_p1};

  for (genvar i = 0; i < NUM_CARS; i++) begin : g_car
    lap_check u_lap (
      .pclk               (pclk),
      .rst                (rst),
      .lap_finished       (lap_fin[i]),
      .checkpoints_passed (lap_ckpt[i]),
      .lap_valid          (lap_valid[i])
    );
  end

  sec_tick #(.CLK_HZ(CLK_HZ)) u_tick (
    .pclk (pclk),
    .rst  (rst),
    .en   (state_q == ST_COUNTDOWN || state_q == ST_RACING),
    .clr  (go),
    .tick (tick)
  );

  always_comb begin
    state_n = state_q;
    cd_n    = countdown;
    act_n   = race_active;
    clr_n   = 1'b0;
    laps_n  = laps_q;
    time_n  = race_time;
    win_n   = winner;
    go      = 1'b0;
    done    = '0;

    if (abort) begin
      // Results stay on display; the trackers are not cleared here.
      if (state_q != ST_IDLE) begin
        state_n = ST_IDLE;
        act_n   = 1'b0;
        cd_n    = 2'd0;
      end
    end else begin
      case (state_q)
        ST_IDLE, ST_FINISHED: begin
          if (start) begin
            go      = 1'b1;
            state_n = ST_COUNTDOWN;
            cd_n    = CD_W;
            clr_n   = 1'b1;
            laps_n  = '0;
            time_n  = 10'd0;
            win_n   = WIN_NONE;
          end
        end
        ST_COUNTDOWN: begin
          if (tick) begin
            if (countdown <= 2'd1) begin
              state_n = ST_RACING;
              cd_n    = 2'd0;
              act_n   = 1'b1;
            end else begin
              cd_n = countdown - 2'd1;
            end
          end
        end
        ST_RACING: begin
          if (tick && race_time != TIME_MAX) time_n = race_time + 10'd1;
          for (int i = 0; i < NUM_CARS; i++) begin
            if (lap_valid[i] && laps_q[i] < LAPS_W) laps_n[i] = laps_q[i] + 4'd1;
            done[i] = (laps_n[i] == LAPS_W);
          end
          if (|done) begin
            state_n = ST_FINISHED;
            act_n   = 1'b0;
            win_n   = (&done)   ? WIN_DRAW :
                      (done[0]) ? WIN_P1   : WIN_P2;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      countdown   <= 2'd0;
      race_active <= 1'b0;
      ckpt_clear  <= 1'b0;
      laps_q      <= '0;
      race_time   <= 10'd0;
      winner      <= WIN_NONE;
    end else begin
      state_q     <= state_n;
      countdown   <= cd_n;
      race_active <= act_n;
      ckpt_clear  <= clr_n;
      laps_q      <= laps_n;
      race_time   <= time_n;
      winner      <= win_n;
    end
  end

  assign state   = state_q;
  assign laps_p1 = laps_q[0];
  assign laps_p2 = laps_q[1];

endmodule

// File: doc/race_controller.md
Name: race_controller

Overview:
- Sequences a two-player race: idle, countdown, racing, finished.
- Consumes the per-car lap/checkpoint flags from the two checkpoint trackers.
- Validates and counts laps, runs a seconds timer, declares the winner, and issues a clear pulse to the trackers at race start.
- Sits between the per-car checkpoint logic and the HUD/renderer and car-motion logic, which read its state and counters.

Parameters:
- LAPS, 3, laps required to finish (1..15).
- CLK_HZ, 65_000_000, pclk frequency; one-second tick period in cycles.
- COUNTDOWN_S, 3, countdown length in seconds (1..3).

Ports:
- pclk  in  1  pixel clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level; sampled in IDLE and FINISHED only.
- abort  in  1  level; forces return to IDLE from any non-IDLE state.
- lap_finished_p1  in  1  level; car 1 is in the finish zone.
- checkpoints_passed_p1  in  1  car 1 has passed all checkpoints; valid in the first cycle of lap_finished_p1.
- lap_finished_p2  in  1  as above, car 2.
- checkpoints_passed_p2  in  1  as above, car 2.
- state  out  2  0 IDLE, 1 COUNTDOWN, 2 RACING, 3 FINISHED.
- countdown  out  2  seconds remaining in COUNTDOWN, else 0.
- race_active  out  1  high only in RACING; gates car motion.
- ckpt_clear  out  1  one-cycle pulse to reset the checkpoint trackers.
- laps_p1  out  4  completed valid laps, car 1.
- laps_p2  out  4  completed valid laps, car 2.
- race_time  out  10  whole seconds elapsed in RACING; saturates at 999.
- winner  out  2  0 none, 1 car 1, 2 car 2, 3 draw.

Behaviour:
- Reset: async assert forces all outputs to 0, state to IDLE, prescaler to 0, and edge-detect registers to 0.
- All outputs are registered.
- IDLE -> COUNTDOWN when start=1.
  - On the transition cycle: ckpt_clear=1 for exactly one cycle; laps_p1, laps_p2, race_time and winner cleared; countdown loaded with COUNTDOWN_S; prescaler cleared.
- Prescaler:
  - Counts 0..CLK_HZ-1 in COUNTDOWN and RACING, holds 0 otherwise.
  - Tick is asserted when the count = CLK_HZ-1; the counter wraps to 0.
- COUNTDOWN:
  - On each tick, countdown decrements.
  - A tick with countdown=1 moves to RACING with countdown=0 and race_active=1 on the next cycle.
- RACING:
  - Tick increments race_time unless it is 999.
  - Valid lap for car N: rising edge of lap_finished_pN, with checkpoints_passed_pN=1 in that same cycle. Edge detection uses the registered previous value of lap_finished_pN.
  - A valid lap increments laps_pN on the next cycle.
  - Holding in the finish zone produces no further counts.
  - An invalid rising edge (checkpoints_passed_pN=0) produces no count.
  - When a car's increment takes it to LAPS: the next state is FINISHED, race_active drops in the same cycle the lap count updates, and winner is set (1 or 2).
  - Both cars reaching LAPS on the same cycle: winner=3.
  - Laps counted in RACING only; lap edges in COUNTDOWN, IDLE or FINISHED are ignored.
  - laps_pN never exceeds LAPS.
- FINISHED:
  - Holds laps, race_time and winner.
  - start=1 behaves as in IDLE: new countdown, ckpt_clear pulse, counters cleared.
- abort:
  - Has priority over start and tick.
  - Next state is IDLE, race_active=0 and countdown=0.
  - Lap, time and winner values are held for display; no ckpt_clear is issued.
- Simultaneous tick and valid lap in RACING: both take effect in the same cycle.
- Reset mid-race: immediate return to IDLE with all outputs 0; no ckpt_clear is generated (the trackers share rst).

Decomposition:
- Package race_pkg holds:
  - state encoding constants: ST_IDLE, ST_COUNTDOWN, ST_RACING, ST_FINISHED;
  - winner codes: WIN_NONE, WIN_P1, WIN_P2, WIN_DRAW;
  - TIME_MAX=999.
- One sub-module, sec_tick: parameterised CLK_HZ prescaler with enable and synchronous clear, producing a one-cycle tick.
- Per-car lap validation (edge detect plus qualify) is identical for both cars; instance it twice or use a generate loop.

Test Plan (CLK_HZ=10, COUNTDOWN_S=3, LAPS=2):
- Reset, then start pulse -> ckpt_clear high for 1 cycle; state=1 with countdown 3, 2, 1 at 10-cycle intervals; state=2 and race_active=1 after 30 cycles.
- RACING, car 1 lap_finished rises with checkpoints_passed=1, held 20 cycles -> laps_p1=1 exactly once.
- Car 2 lap_finished rises with checkpoints_passed=0 -> laps_p2 stays 0.
- Car 1 completes a second valid lap -> laps_p1=2, state=3, winner=1, race_active=0; further lap edges leave the counters unchanged.
- Both cars at 1 lap, valid rising edges on the same cycle -> laps_p1=laps_p2=2, winner=3.
- Two abort/reset cases:
  - abort asserted mid-RACING -> state=0 next cycle, race_active=0, laps held.
  - rst asserted mid-COUNTDOWN (async, between clock edges) -> all outputs 0 immediately.
- Long race with no laps for 10000 ticks -> race_time saturates at 999.
